buffer_reader: RTL and testbench

Consumer for the read port of the sample buffer. Requests stored 9-bit samples one at a time using the buffer's valid/read/read-ack handshake. Packs a fixed number of samples into a framed byte stream for the byte-wide transmitter: a header byte, two bytes per sample, and a modulo-256 checksum. Sits between the sample buffer and the serial link to the host.

---
 rtl/buffer_reader_pkg.sv | 20 ++
 rtl/buffer_reader_ack_timer.sv | 30 +++
 rtl/buffer_reader.sv | 141 ++++++++++++++
 tb/tb_buffer_reader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_reader_pkg.sv
// Shared constants and types for the sample-buffer reader and the sample buffer.
package buffer_reader_pkg;

  localparam int         DEF_DATA_WIDTH = 9;
  localparam logic [7:0] DEF_HEADER     = 8'hA5;

  typedef logic [DEF_DATA_WIDTH-1:0] sample_t;
  typedef logic [7:0]                byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_REQ,
    ST_WAIT_ACK,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_CHECKSUM
  } state_t;

endpackage

// File: rtl/buffer_reader_ack_timer.sv
// Read-ack timeout: loaded on each new request, counts down while the ack is outstanding.
module ack_timer #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Terminal count: the wait has lasted ACK_TIMEOUT cycles once this cycle ends.
  assign expired = (cnt == '0);

endmodule

// File: rtl/buffer_reader.sv
// Reads samples from the sample buffer and frames them as header, hi/lo byte pairs, checksum.
//   state     | meaning
//   IDLE      | waiting for the buffer to hold a sample
//   HEADER    | presenting the header byte
//   REQ       | waiting for buf_valid to issue a read
//   WAIT_ACK  | read outstanding, waiting for ack or timeout
//   SEND_HI   | presenting sample bits above bit 7
//   SEND_LO   | presenting sample bits [7:0]
//   CHECKSUM  | presenting the payload checksum
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int         DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int         FRAME_LEN   = 16,
  parameter int         ACK_TIMEOUT = 64,
  parameter logic [7:0] HEADER      = DEF_HEADER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_data,
  input  logic                  buf_valid,
  output logic                  buf_read,
  input  logic                  buf_read_ack,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t     state;
  byte_t      lo_byte;
  byte_t      checksum;
  logic [7:0] sample_cnt;
  logic       tx_xfer;
  logic       timer_start;
  logic       timer_en;
  logic       timer_expired;

  assign tx_xfer     = tx_valid && tx_ready;
  assign timer_start = (state == ST_REQ) && buf_valid;
  assign timer_en    = (state == ST_WAIT_ACK) && !buf_read_ack;

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      buf_read    <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      lo_byte     <= '0;
      checksum    <= '0;
      sample_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (buf_valid) begin
            tx_data    <= HEADER;
            tx_valid   <= 1'b1;
            busy       <= 1'b1;
            checksum   <= '0;
            sample_cnt <= '0;
            state      <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (tx_xfer) begin
            tx_valid <= 1'b0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (buf_valid) begin
            buf_read <= 1'b1;
            state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // An ack on the expiry cycle wins over the timeout.
          if (buf_read_ack) begin
            buf_read <= 1'b0;
            lo_byte  <= buf_data[7:0];
            tx_data  <= byte_t'(buf_data >> 8);
            tx_valid <= 1'b1;
            state    <= ST_SEND_HI;
          end else if (timer_expired) begin
            buf_read    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_SEND_HI: begin
          if (tx_xfer) begin
            checksum <= checksum + tx_data;
            tx_data  <= lo_byte;
            state    <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (tx_xfer) begin
            checksum   <= checksum + tx_data;
            sample_cnt <= sample_cnt + 8'd1;
            if (sample_cnt == LAST_IDX) begin
              tx_data <= checksum + tx_data;
              state   <= ST_CHECKSUM;
            end else begin
              tx_valid <= 1'b0;
              state    <= ST_REQ;
            end
          end
        end
        ST_CHECKSUM: begin
          if (tx_xfer) begin
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Scoreboard bench for buffer_reader: buffer/transmitter models driven with random timing.
module tb_buffer_reader;
  import buffer_reader_pkg::*;

  localparam int FRAME_LEN   = 3;
  localparam int ACK_TIMEOUT = 4;
  localparam int DW          = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] buf_data = '0;
  logic          buf_valid = 1'b0;
  logic          buf_read;
  logic          buf_read_ack = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;

  buffer_reader #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FRAME_LEN),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .HEADER     (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_data    (buf_data),
    .buf_valid   (buf_valid),
    .buf_read    (buf_read),
    .buf_read_ack(buf_read_ack),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] buf_q[$];
  logic [7:0]    fsum;

  // Stimulus knobs
  int rdy_pct    = 100;
  int starve_pct = 0;
  int junk_pct   = 0;
  bit starve     = 1'b0;
  int dly_lo     = 1;
  int dly_hi     = 1;
  int force_dly  = -1;

  int ack_cnt     = 0;
  int done_cnt    = 0;
  int busy_cycles = 0;
  bit exp_terr    = 1'b0;

  // Reference framing: header, hi byte, lo byte per sample, then the byte sum mod 256.
  task automatic push_sample(input logic [DW-1:0] s, input int idx);
    logic [7:0] hi;
    hi = 8'(s >> 8);
    if (idx == 0) begin
      exp_q.push_back('{8'hA5, 1'b0});
      fsum = 8'h00;
    end
    buf_q.push_back(s);
    exp_q.push_back('{hi, 1'b0});
    exp_q.push_back('{s[7:0], 1'b0});
    fsum = fsum + hi + s[7:0];
    if (idx == FRAME_LEN - 1) exp_q.push_back('{fsum, 1'b1});
  endtask

  task automatic push_frame3(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    push_sample(a, 0);
    push_sample(b, 1);
    push_sample(c, 2);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: frame not finished after %0d cycles, %0d bytes outstanding", name, n, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_acks(input int target, input string name);
    int n;
    n = 0;
    while (ack_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ack_cnt < target) begin
      errors++;
      $display("FAIL %s: got %0d acks expected %0d", name, ack_cnt, target);
    end
  endtask

  // Buffer and transmitter models: inputs change 1 time unit after the rising edge.
  int rd_cycles = 0;
  int cur_dly   = 0;
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready     = (int'($urandom_range(99)) < rdy_pct);
    buf_valid    = (buf_q.size() > 0) && !starve && !(int'($urandom_range(99)) < starve_pct);
    buf_read_ack = 1'b0;
    buf_data     = DW'($urandom);
    if (!rst) begin
      rd_cycles = 0;
    end else if (buf_read) begin
      rd_cycles++;
      if (rd_cycles == 1) begin
        if (force_dly >= 0) begin
          cur_dly   = force_dly;
          force_dly = -1;
        end else begin
          cur_dly = int'($urandom_range(dly_hi, dly_lo));
        end
      end
      if (rd_cycles == cur_dly + 1 && buf_q.size() > 0) begin
        buf_read_ack = 1'b1;
        buf_data     = buf_q.pop_front();
        ack_cnt++;
      end
    end else begin
      rd_cycles = 0;
      if (int'($urandom_range(99)) < junk_pct) buf_read_ack = 1'b1;
    end
  end

  // Monitor: byte scoreboard, hold stability, frame_done timing, read-run lengths.
  bit         done_due  = 1'b0;
  bit         pv        = 1'b0;
  bit         pr        = 1'b0;
  logic [7:0] pd        = '0;
  int         run_len   = 0;
  bit         run_acked = 1'b0;
  exp_t       e;
  initial forever begin
    @(negedge clk);
    if (busy) busy_cycles++;
    if (!rst) begin
      done_due  = 1'b0;
      pv        = 1'b0;
      pr        = 1'b0;
      run_len   = 0;
      run_acked = 1'b0;
      exp_terr  = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, pd);
      end
      if (frame_done || done_due) begin
        chk("frame_done_pulse", frame_done, done_due);
        if (done_due) chk("busy_after_frame", busy, 0);
      end
      if (frame_done) done_cnt++;
      done_due = 1'b0;
      if (tx_valid && !busy) chk("busy_during_tx", busy, 1);
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte: got %0h expected no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e.b) begin
            errors++;
            $display("FAIL tx_byte: got %0h expected %0h", tx_data, e.b);
          end
          done_due = e.last;
        end
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
      if (buf_read) begin
        run_len++;
        if (buf_read_ack) run_acked = 1'b1;
      end else if (run_len > 0) begin
        if (run_acked) begin
          chk("acked_read_len_ok", run_len <= ACK_TIMEOUT, 1);
        end else begin
          chk("timeout_read_len", run_len, ACK_TIMEOUT);
          exp_terr = 1'b1;
        end
        chk("timeout_err", timeout_err, exp_terr);
        run_len   = 0;
        run_acked = 1'b0;
      end
    end
  end

  int a0;
  int d0;
  bit seen;
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_buf_read", buf_read, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean frame: ready always high, ack one cycle after the read.
    busy_cycles = 0;
    push_frame3(9'h1FF, 9'h003, 9'h080);
    wait_drain("frame_basic", 300);
    chk("frame_cycles", busy_cycles, 1 + 5 * FRAME_LEN + 1);
    chk("frame_done_count", done_cnt, 1);

    // Backpressure on the first HI byte, then the buffer runs dry for 20 cycles.
    a0 = ack_cnt;
    push_frame3(9'h1FF, 9'h0AA, 9'h155);
    wait_acks(a0 + 1, "bp_first_ack");
    rdy_pct = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hi_valid", tx_valid, 1);
      chk("bp_hi_data", tx_data, 8'h01);
    end
    rdy_pct = 100;
    starve  = 1'b1;
    seen    = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (buf_read) seen = 1'b1;
    end
    chk("starve_no_read", seen, 0);
    chk("starve_busy", busy, 1);
    starve = 1'b0;
    wait_drain("frame_bp_starve", 400);

    // Ack on the expiry cycle is taken and does not flag a timeout.
    force_dly = ACK_TIMEOUT - 1;
    push_frame3(9'h123, 9'h045, 9'h1C0);
    wait_drain("frame_ack_at_expiry", 300);
    chk("terr_ack_on_expiry", timeout_err, 0);

    // No ack at all for the first request: timeout, then retry of the same slot.
    force_dly = ACK_TIMEOUT + 2;
    push_frame3(9'h0F0, 9'h10F, 9'h001);
    wait_drain("frame_timeout_retry", 300);
    chk("terr_set", timeout_err, 1);

    // Reset while the second sample's LO byte is on the bus.
    a0 = ack_cnt;
    push_frame3(9'h1AB, 9'h0CD, 9'h1EF);
    wait_acks(a0 + 2, "rst_mid_ack");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    buf_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_buf_read", buf_read, 0);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_timeout_err", timeout_err, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_resume_after_rst", {busy, tx_valid, buf_read}, 0);
    d0 = done_cnt;
    push_frame3(9'h0FE, 9'h1DC, 9'h0BA);
    wait_drain("frame_after_rst", 300);
    chk("frame_after_rst_done", done_cnt - d0, 1);

    // Random traffic: random samples, ready, buffer gaps, ack delays and stray acks.
    rdy_pct    = 70;
    starve_pct = 15;
    junk_pct   = 20;
    dly_lo     = 0;
    dly_hi     = ACK_TIMEOUT + 1;
    d0         = done_cnt;
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) push_sample(DW'($urandom_range(511, 0)), i);
    end
    wait_drain("random_frames", 30000);
    chk("random_frames_done", done_cnt - d0, 30);
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_timeout_err", timeout_err, exp_terr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
